addr_mode_decoder: RTL and testbench

- Front-end decoder for the CPU core. Consumes the fetched byte stream: one opcode byte, then 0–2 operand bytes.
- Classifies the opcode into exactly one 6502 addressing mode, or none for unknown opcodes.
- Collects the operand bytes, then presents opcode, operand and one-hot mode flags with a single-cycle newinst pulse.
- Feeds the addressing-mode consumers and trace/debug printers downstream.

---
 rtl/addr_mode_decoder.sv | 138 +++++++++++++
 tb/tb_addr_mode_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/addr_mode_decoder.sv
// addr_mode_decoder: 6502 opcode/operand collector with one-hot addressing-mode flags; optional ILLEGAL_TRAP_EN halts on cc=11 opcodes.
module addr_mode_decoder #(
  parameter logic [7:0] RESET_INSTR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  instruction,
  output logic [15:0] operand,
  output logic [1:0]  num_bytes,
  output logic        newinst,
  output logic        immediate,
  output logic        absolute,
  output logic        zpg_absolute,
  output logic        implied,
  output logic        accumulator,
  output logic        abs_indexed_x,
  output logic        abs_indexed_y,
  output logic        zpg_indexed_x,
  output logic        zpg_indexed_y,
  output logic        indirect,
  output logic        indirect_x,
  output logic        indirect_y,
  output logic        relative
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);
  typedef enum logic [1:0] {S_OPCODE, S_OP_LO, S_OP_HI, S_EMIT} state_t;
  localparam logic [12:0] IMM = 13'h0001, ABS = 13'h0002, ZPG = 13'h0004, IMP = 13'h0008,
                          ACC = 13'h0010, ABX = 13'h0020, ABY = 13'h0040, ZPX = 13'h0080,
                          ZPY = 13'h0100, IND = 13'h0200, INX = 13'h0400, INY = 13'h0800,
                          REL = 13'h1000;
  localparam logic [12:0] ONE = IMM | ZPG | ZPX | ZPY | INX | INY | REL;
  localparam logic [12:0] TWO = ABS | ABX | ABY | IND;
  state_t state, state_n;
  logic [12:0] dm, mode_r, mode;
  logic [1:0] dc, cnt_r;
  logic [7:0] op_r, lo_r;
  logic [2:0] aaa, bbb;
  logic xfer, load, halt;
  assign aaa = in_data[7:5];
  assign bbb = in_data[4:2];
  always_comb begin
    dm = '0;
    case (in_data[1:0])
      2'b01:
        case (bbb)
          3'd0: dm = INX;
          3'd1: dm = ZPG;
          3'd2: dm = IMM;
          3'd3: dm = ABS;
          3'd4: dm = INY;
          3'd5: dm = ZPX;
          3'd6: dm = ABY;
          default: dm = ABX;
        endcase
      2'b10:
        case (bbb)
          3'd0: dm = IMM;
          3'd1: dm = ZPG;
          3'd2: dm = aaa[2] ? IMP : ACC;
          3'd3: dm = ABS;
          3'd5: dm = (aaa[2:1] == 2'b10) ? ZPY : ZPX;
          3'd7: dm = (aaa == 3'b101) ? ABY : ABX;
          default: dm = IMP;
        endcase
      2'b00:
        case (bbb)
          3'd0: dm = aaa[2] ? IMM : (aaa == 3'b001) ? ABS : IMP;
          3'd1: dm = ZPG;
          3'd3: dm = (aaa == 3'b011) ? IND : ABS;
          3'd4: dm = REL;
          3'd5: dm = ZPX;
          3'd7: dm = ABX;
          default: dm = IMP;
        endcase
      default: dm = '0;
    endcase
  end
  assign dc = |(dm & ONE) ? 2'd1 : |(dm & TWO) ? 2'd2 : 2'd0;
  assign in_ready = !flush && !halt && state != S_EMIT;
  assign newinst = state == S_EMIT && !flush;
  assign xfer = in_valid && in_ready;
  always_comb begin
    state_n = state;
    if (flush || state == S_EMIT) state_n = S_OPCODE;
    else if (xfer)
      state_n = (state == S_OPCODE) ? (dc != 2'd0 ? S_OP_LO : S_EMIT) :
                (state == S_OP_LO) ? (cnt_r == 2'd2 ? S_OP_HI : S_EMIT) : S_EMIT;
  end
  assign load = xfer && state_n == S_EMIT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OPCODE;
      op_r <= 8'h00;
      lo_r <= 8'h00;
      mode_r <= '0;
      cnt_r <= 2'd0;
      instruction <= RESET_INSTR;
      operand <= 16'h0000;
      num_bytes <= 2'd0;
      mode <= '0;
    end else begin
      state <= state_n;
      if (xfer && state == S_OPCODE) begin
        op_r <= in_data;
        mode_r <= dm;
        cnt_r <= dc;
      end
      if (xfer && state == S_OP_LO) lo_r <= in_data;
      // Outputs move only on the edge entering S_EMIT, merging the final byte in flight.
      if (load) begin
        instruction <= (state == S_OPCODE) ? in_data : op_r;
        mode <= (state == S_OPCODE) ? dm : mode_r;
        num_bytes <= (state == S_OPCODE) ? dc : cnt_r;
        operand <= (state == S_OP_HI) ? {in_data, lo_r} :
                   (state == S_OP_LO) ? {8'h00, in_data} : 16'h0000;
      end
    end
  end
`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal <= 1'b0;
    else if (load && state == S_OPCODE && in_data[1:0] == 2'b11) illegal <= 1'b1;
  end
  assign halt = illegal;
`else
  assign halt = 1'b0;
`endif
  assign {relative, indirect_y, indirect_x, indirect, zpg_indexed_y, zpg_indexed_x,
          abs_indexed_y, abs_indexed_x, accumulator, implied, zpg_absolute, absolute,
          immediate} = mode;
endmodule

// File: tb/tb_addr_mode_decoder.sv
// tb_addr_mode_decoder: directed byte streams with a queue scoreboard checked on each newinst pulse.
module tb_addr_mode_decoder;
  localparam logic [12:0] F_IMM = 13'h0001, F_ABS = 13'h0002, F_ZPG = 13'h0004, F_IMP = 13'h0008,
                          F_ACC = 13'h0010, F_ABY = 13'h0040, F_ZPY = 13'h0100, F_IND = 13'h0200,
                          F_REL = 13'h1000;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, newinst;
  logic [7:0] instruction;
  logic [15:0] operand;
  logic [1:0] num_bytes;
  logic immediate, absolute, zpg_absolute, implied, accumulator, abs_indexed_x, abs_indexed_y;
  logic zpg_indexed_x, zpg_indexed_y, indirect, indirect_x, indirect_y, relative;
`ifdef ILLEGAL_TRAP_EN
  logic illegal;
`endif
  logic [12:0] flags;
  assign flags = {relative, indirect_y, indirect_x, indirect, zpg_indexed_y, zpg_indexed_x,
                  abs_indexed_y, abs_indexed_x, accumulator, implied, zpg_absolute, absolute,
                  immediate};
  addr_mode_decoder dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .instruction(instruction), .operand(operand), .num_bytes(num_bytes),
    .newinst(newinst), .immediate(immediate), .absolute(absolute), .zpg_absolute(zpg_absolute),
    .implied(implied), .accumulator(accumulator), .abs_indexed_x(abs_indexed_x),
    .abs_indexed_y(abs_indexed_y), .zpg_indexed_x(zpg_indexed_x), .zpg_indexed_y(zpg_indexed_y),
    .indirect(indirect), .indirect_x(indirect_x), .indirect_y(indirect_y), .relative(relative)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] i;
    logic [15:0] o;
    logic [1:0] n;
    logic [12:0] f;
    int due;
  } exp_t;
  exp_t q[$];
  int nvec = 0, nerr = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string name);
    chk(name, {instruction, operand, num_bytes, flags, newinst, in_ready},
        {8'h00, 16'h0000, 2'd0, 13'h0000, 1'b0, 1'b1});
  endtask
  task automatic send(input logic [7:0] b, input bit last, input logic [7:0] ei,
                      input logic [15:0] eo, input logic [1:0] en, input logic [12:0] ef);
    int k;
    exp_t e;
    @(negedge clk);
    in_valid = 1;
    in_data = b;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL accept_%h in_ready=0 required=1", b);
    end else begin
      @(posedge clk);
      #1;
      if (last) begin
        e.i = ei; e.o = eo; e.n = en; e.f = ef; e.due = cyc;
        q.push_back(e);
      end
    end
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && newinst) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_newinst instr=%h required=none", instruction);
      end else begin
        e = q.pop_front();
        if ({instruction, operand, num_bytes, flags} !== {e.i, e.o, e.n, e.f}) begin
          nerr++;
          $display("FAIL decode_%h got=%h/%h/%0d/%h required=%h/%h/%0d/%h", e.i,
                   instruction, operand, num_bytes, flags, e.i, e.o, e.n, e.f);
        end
        nvec++;
        if (cyc != e.due) begin
          nerr++;
          $display("FAIL latency_%h got_cycle=%0d required=%0d", e.i, cyc, e.due);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running required=finished");
    $fatal(1);
  end
  initial begin
    #2;
    chk_reset("reset_state");
    @(negedge clk);
    rst = 0;
    send(8'hA9, 0, 0, 0, 0, 0);
    send(8'h42, 1, 8'hA9, 16'h0042, 2'd1, F_IMM);
    send(8'h6C, 0, 0, 0, 0, 0);
    send(8'h34, 0, 0, 0, 0, 0);
    send(8'h12, 1, 8'h6C, 16'h1234, 2'd2, F_IND);
    send(8'h0A, 1, 8'h0A, 16'h0000, 2'd0, F_ACC);
    send(8'hB6, 0, 0, 0, 0, 0);
    send(8'h10, 1, 8'hB6, 16'h0010, 2'd1, F_ZPY);
    send(8'hBE, 0, 0, 0, 0, 0);
    send(8'h00, 0, 0, 0, 0, 0);
    send(8'h20, 1, 8'hBE, 16'h2000, 2'd2, F_ABY);
    send(8'hD0, 0, 0, 0, 0, 0);
    send(8'hFE, 1, 8'hD0, 16'h00FE, 2'd1, F_REL);
    send(8'h8D, 0, 0, 0, 0, 0);
    send(8'h00, 0, 0, 0, 0, 0);
    @(negedge clk);
    in_data = 8'hEA;
    flush = 1;
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    chk("flush_hold_instr", {56'd0, instruction}, 64'hD0);
    send(8'hEA, 1, 8'hEA, 16'h0000, 2'd0, F_IMP);
    send(8'h20, 0, 0, 0, 0, 0);
    send(8'h34, 0, 0, 0, 0, 0);
    in_valid = 0;
    #3;
    rst = 1;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    rst = 0;
    send(8'h60, 1, 8'h60, 16'h0000, 2'd0, F_IMP);
    send(8'h03, 1, 8'h03, 16'h0000, 2'd0, 13'h0000);
`ifdef ILLEGAL_TRAP_EN
    in_valid = 1;
    in_data = 8'hEA;
    @(negedge clk);
    chk("illegal_set", {63'd0, illegal}, 64'd1);
    begin
      logic seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        seen = seen | in_ready | !illegal;
      end
      chk("illegal_halt", {63'd0, seen}, 64'd0);
    end
    in_valid = 0;
    rst = 1;
    #1;
    chk("illegal_cleared", {63'd0, illegal}, 64'd0);
    @(negedge clk);
    rst = 0;
`else
    send(8'hEA, 1, 8'hEA, 16'h0000, 2'd0, F_IMP);
    idle();
`endif
    repeat (6) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
